lfsr_grant_sched: RTL
=====================

Name: lfsr_grant_sched

Overview:
- Shares one 16-bit pseudo-random stream among N_REQ consumers, e.g. reservoir input-weight generators and dither/noise injectors.
- Owns the LFSR state register and seeds it. Runs a warm-up before serving.
- Hands out each LFSR word to exactly one requester, using round-robin arbitration and registered grant/data outputs.
- Sits between the audio-RC compute lanes and the noise source, so lanes never see duplicate or correlated words.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- SEED, 16'hACE1, reset/default seed. Must be nonzero.
- WARMUP, 16, LFSR steps discarded after every seed load (0..255).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- seed_in  in  16  seed value, captured on seed_load_in.
- seed_load_in  in  1  single-cycle pulse: reseed and re-warm.
- req_in  in  N_REQ  level requests, one bit per consumer.
- gnt_out  out  N_REQ  one-hot grant, registered.
- valid_out  out  1  data_out carries a granted word this cycle.
- data_out  out  16  LFSR word for the granted requester.
- ready_out  out  1  high in SERVE state.
- zero_seed_out  out  1  sticky: last load had seed_in==0, so SEED was substituted.

Behaviour:
- LFSR step rule, applied to state q:
  - q[15]<=q[14]^q[15]
  - q[14:3]<=q[13:2]
  - q[2]<=q[1]^q[15]
  - q[1]<=q[0]
  - q[0]<=q[15]
  - Examples: 16'h8000 -> 16'h8005 -> 16'h800F; 16'h0001 -> 16'h0002.
- Reset (async, rst_in high):
  - q=SEED, state=WARMUP, warm-up counter=0, RR pointer=0.
  - gnt_out=0, valid_out=0, data_out=0, ready_out=0, zero_seed_out=0.
- FSM states: WARMUP, SERVE.
- WARMUP:
  - q steps every cycle and the counter increments.
  - No grants; valid_out=0, gnt_out=0, data_out holds its last value.
  - After WARMUP steps, next state is SERVE.
  - If WARMUP==0, SERVE is entered on the first cycle after the load or reset.
- SERVE:
  - ready_out=1.
  - Each cycle, req_in is sampled. If any bit is set, select the first set bit searching upward from (ptr+1) mod N_REQ, wrapping. ptr is the index granted most recently; 0 after reset, so index 1 has first priority.
  - At the next edge:
    - gnt_out = one-hot of the winner; valid_out=1.
    - data_out = q as it was before this edge.
    - q steps once; ptr = winner.
  - Latency: req to gnt/valid/data is 1 cycle.
  - If no req: gnt_out=0, valid_out=0, q does not step, data_out holds.
  - q steps only on a grant, so each word goes to exactly one requester and no word is skipped.
  - A sole persistent requester is granted every cycle.
- seed_load_in (any state):
  - At the next edge, q = seed_in, or SEED if seed_in==0.
  - zero_seed_out = (seed_in==0). The flag stays set until a load with nonzero seed_in.
  - Counter=0, state=WARMUP, gnt_out=0, valid_out=0, ready_out=0. ptr is unchanged.
  - A load takes priority over a simultaneous grant: that request is not served and no word is consumed.
- Reset mid-operation clears everything asynchronously. The first grant after reset occurs only after the full warm-up.
- Invariants:
  - q is never 0. Seeding guarantees this, and the step rule maps nonzero to nonzero.
  - gnt_out is at most one-hot.
  - valid_out == |gnt_out.

Test Plan:
- Reset with SEED=16'h8000, WARMUP=0; hold req_in=4'b0001 from the first SERVE cycle -> grants on consecutive cycles to idx0 with data_out=16'h8000, 16'h8005, 16'h800F.
- WARMUP=16, default SEED, req_in=4'b1111 held from reset -> ready_out rises after 16 cycles. First gnt_out=4'b0010, then 4'b0100, 4'b1000, 4'b0001, repeating. data_out matches the 17th, 18th, ... values of a software model of the step rule from 16'hACE1.
- In SERVE, req_in=4'b0101 for 4 cycles, then 0 for 3 cycles, then 4'b0101 again -> grants alternate idx2, idx0, idx2, idx0. The idle cycles give valid_out=0, a held data_out and no q step. The next grant is idx2, with data continuing the sequence with no gap.
- seed_load_in with seed_in=16'h0001 in the same cycle as req_in=4'b0010, WARMUP=0 -> no grant that cycle, ready_out drops for 1 cycle. The next grants give 16'h0001, 16'h0002.
- seed_load_in with seed_in=0 -> q=SEED and zero_seed_out=1. A later load with seed_in=16'h1234 clears the flag.
- Assert rst_in asynchronously mid-SERVE while valid_out=1 -> all outputs go to 0 immediately, without a clock edge. After release, the warm-up repeats and the sequence restarts from SEED.

Source files
------------

// File: rtl/lfsr_grant_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lfsr_grant_sched
//  Brief    : Shares one 16-bit LFSR stream among N_REQ requesters with
//             round-robin grants; each word goes to exactly one consumer.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_grant_sched #(
    parameter int          N_REQ  = 4,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int          WARMUP = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [15:0]      seed_in,
    input  logic             seed_load_in,
    input  logic [N_REQ-1:0] req_in,
    output logic [N_REQ-1:0] gnt_out,
    output logic             valid_out,
    output logic [15:0]      data_out,
    output logic             ready_out,
    output logic             zero_seed_out
);

    localparam int          c_ptr_w     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]  c_warm_last = 8'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [c_ptr_w:0] c_nreq = (c_ptr_w+1)'(N_REQ);

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_SERVE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [c_ptr_w-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic [15:0]        data_q, data_d;
    logic               zero_q, zero_d;

    logic               w_any;
    logic [c_ptr_w-1:0] w_win_idx;
    logic [c_ptr_w:0]   w_sum;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14] ^ q[15], q[13:2], q[1] ^ q[15], q[0], q[15]};
    endfunction

    // Scan from the farthest candidate down to ptr+1 so the nearest set bit
    // after the last winner overwrites everything else.
    always_comb begin
        w_any     = |req_in;
        w_win_idx = ptr_q;
        w_sum     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_sum = {1'b0, ptr_q} + (c_ptr_w+1)'(i);
            if (w_sum >= c_nreq) begin
                w_sum = w_sum - c_nreq;
            end
            if (req_in[w_sum[c_ptr_w-1:0]]) begin
                w_win_idx = w_sum[c_ptr_w-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        data_d  = data_q;
        zero_d  = zero_q;

        if (seed_load_in) begin
            // A zero seed would lock the LFSR at zero, so fall back to SEED.
            lfsr_d  = (seed_in == 16'h0000) ? SEED : seed_in;
            zero_d  = (seed_in == 16'h0000);
            cnt_d   = '0;
            state_d = ST_WARMUP;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (WARMUP == 0) begin
                        state_d = ST_SERVE;
                    end else begin
                        lfsr_d = lfsr_step(lfsr_q);
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == c_warm_last) begin
                            state_d = ST_SERVE;
                        end
                    end
                end
                ST_SERVE: begin
                    if (w_any) begin
                        gnt_d[w_win_idx] = 1'b1;
                        valid_d          = 1'b1;
                        data_d           = lfsr_q;
                        lfsr_d           = lfsr_step(lfsr_q);
                        ptr_d            = w_win_idx;
                    end
                end
                default: state_d = ST_WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_WARMUP;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end

    assign gnt_out       = gnt_q;
    assign valid_out     = valid_q;
    assign data_out      = data_q;
    assign ready_out     = (state_q == ST_SERVE);
    assign zero_seed_out = zero_q;

endmodule
`default_nettype wire
